clint_timer_pipe_ctrl: RTL and testbench

//  - Core-local timer plus pipeline hazard arbiter, instantiated inside the CLINT/trap unit.
//  - Holds the 64-bit mtime/mtimecmp pair, memory-mapped as 32-bit words, and flags a timer-interrupt condition.
//  - Folds every stall/flush request (trap FSM, memory waits, mul/div, load-use, jump, compressed fetch) into one stall vector and one flush vector.
//  - Vectors drive the 6-entry pipeline: PC, IF/ID, ID/EX, EX/MEM, MEM/WB, WB.

---
 rtl/clint_timer_pipe_ctrl_if.sv | 36 +++
 rtl/clint_timer_pipe_ctrl.sv | 144 ++++++++++++++
 tb/tb_clint_timer_pipe_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/clint_timer_pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// clint_timer_pipe_ctrl_if
//   Register-access bus for the core-local timer (mtime / mtimecmp).
//   The trap unit (master) presents a byte address, an optional write strobe
//   and write data. The timer (slave) returns combinational read data and the
//   timer-interrupt condition.
//
//   mtime_addr_i         master -> slave  32  byte address of register access
//   mtime_write_valid_i  master -> slave   1  write strobe
//   mtime_wdata_i        master -> slave  32  write data
//   mtime_rdata_o        slave -> master  32  read data for mtime_addr_i
//   mtime_ge_mtime_o     slave -> master   1  mtime >= mtimecmp (unsigned)
// -----------------------------------------------------------------------------
interface clint_timer_pipe_ctrl_if;
    logic [31:0] mtime_addr_i;
    logic        mtime_write_valid_i;
    logic [31:0] mtime_wdata_i;
    logic [31:0] mtime_rdata_o;
    logic        mtime_ge_mtime_o;

    modport master (
        output mtime_addr_i,
        output mtime_write_valid_i,
        output mtime_wdata_i,
        input  mtime_rdata_o,
        input  mtime_ge_mtime_o
    );

    modport slave (
        input  mtime_addr_i,
        input  mtime_write_valid_i,
        input  mtime_wdata_i,
        output mtime_rdata_o,
        output mtime_ge_mtime_o
    );
endinterface

// File: rtl/clint_timer_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// clint_timer_pipe_ctrl
//   Core-local timer plus pipeline hazard arbiter.
//   - 64-bit mtime / mtimecmp, memory-mapped as 32-bit words through `bus`.
//     mtime advances once every TICK_DIV clocks and wraps at 2^64.
//   - All stall / flush requests are folded, by fixed priority, into one
//     stall vector and one flush vector for the 6-entry pipeline
//     (bit 0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB).
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   bus                      slave side of the register-access interface
//   compress_stall           fetch assembling a compressed/split instruction
//   ram_stall_valid_if_i     instruction memory busy
//   ram_stall_valid_mem_i    data memory busy
//   load_use_valid_id_i      load-use hazard in ID
//   jump_valid_ex_i          taken branch/jump resolved in EX
//   alu_mul_div_valid_ex_i   multi-cycle mul/div busy in EX
//   trap_flush_valid_wb_i    trap taken, squash younger instructions
//   trap_stall_valid_wb_i    trap CSR FSM busy, freeze everything
//   stall_o[5:0]             1 = hold stage
//   flush_o[5:0]             1 = load bubble into stage
// -----------------------------------------------------------------------------
module clint_timer_pipe_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int          TICK_DIV  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    clint_timer_pipe_ctrl_if.slave        bus,
    input  logic                          compress_stall,
    input  logic                          ram_stall_valid_if_i,
    input  logic                          ram_stall_valid_mem_i,
    input  logic                          load_use_valid_id_i,
    input  logic                          jump_valid_ex_i,
    input  logic                          alu_mul_div_valid_ex_i,
    input  logic                          trap_flush_valid_wb_i,
    input  logic                          trap_stall_valid_wb_i,
    output logic [5:0]                    stall_o,
    output logic [5:0]                    flush_o
);

    localparam logic [31:0] ADDR_CMP_LO   = BASE_ADDR + 32'h0000_4000;
    localparam logic [31:0] ADDR_CMP_HI   = BASE_ADDR + 32'h0000_4004;
    localparam logic [31:0] ADDR_MTIME_LO = BASE_ADDR + 32'h0000_BFF8;
    localparam logic [31:0] ADDR_MTIME_HI = BASE_ADDR + 32'h0000_BFFC;

    // Prescaler needs at least one bit even when TICK_DIV == 1.
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] prescaler;
    logic [63:0]   mtime;
    logic [63:0]   mtimecmp;
    logic          tick;

    logic wr_cmp_lo, wr_cmp_hi, wr_mtime_lo, wr_mtime_hi;

    assign tick = (prescaler == PW'(TICK_DIV - 1));

    assign wr_cmp_lo   = bus.mtime_write_valid_i && (bus.mtime_addr_i == ADDR_CMP_LO);
    assign wr_cmp_hi   = bus.mtime_write_valid_i && (bus.mtime_addr_i == ADDR_CMP_HI);
    assign wr_mtime_lo = bus.mtime_write_valid_i && (bus.mtime_addr_i == ADDR_MTIME_LO);
    assign wr_mtime_hi = bus.mtime_write_valid_i && (bus.mtime_addr_i == ADDR_MTIME_HI);

    // -------------------------------------------------------------------------
    // Timer state
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others; blocking here would create order-
    // dependent simulation that no longer matches the synthesized flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            mtime     <= '0;
            mtimecmp  <= '1;
        end else begin
            prescaler <= tick ? '0 : prescaler + PW'(1);

            // A write to either mtime half wins over the tick: the written half
            // takes the data, the other half holds and no carry is applied.
            if (wr_mtime_lo) begin
                mtime[31:0] <= bus.mtime_wdata_i;
            end else if (wr_mtime_hi) begin
                mtime[63:32] <= bus.mtime_wdata_i;
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end

            if (wr_cmp_lo) mtimecmp[31:0]  <= bus.mtime_wdata_i;
            if (wr_cmp_hi) mtimecmp[63:32] <= bus.mtime_wdata_i;
        end
    end

    // -------------------------------------------------------------------------
    // Read path and interrupt condition, combinational from current registers
    // -------------------------------------------------------------------------
    // NOTE: every always_comb output gets a default before any branch; a path
    // that leaves it unassigned would infer a latch.
    always_comb begin
        bus.mtime_rdata_o = 32'h0;
        case (bus.mtime_addr_i)
            ADDR_CMP_LO:   bus.mtime_rdata_o = mtimecmp[31:0];
            ADDR_CMP_HI:   bus.mtime_rdata_o = mtimecmp[63:32];
            ADDR_MTIME_LO: bus.mtime_rdata_o = mtime[31:0];
            ADDR_MTIME_HI: bus.mtime_rdata_o = mtime[63:32];
            default:       bus.mtime_rdata_o = 32'h0;
        endcase
    end

    assign bus.mtime_ge_mtime_o = (mtime >= mtimecmp);

    // -------------------------------------------------------------------------
    // Hazard arbiter: first active source wins, lower ones wait their turn.
    // Encodings never set stall and flush on the same stage.
    // -------------------------------------------------------------------------
    always_comb begin
        stall_o = 6'b000000;
        flush_o = 6'b000000;
        if (rst) begin
            stall_o = 6'b000000;
            flush_o = 6'b000000;
        end else if (trap_flush_valid_wb_i) begin
            flush_o = 6'b011110;
        end else if (trap_stall_valid_wb_i) begin
            stall_o = 6'b111111;
        end else if (ram_stall_valid_mem_i) begin
            stall_o = 6'b001111;
            flush_o = 6'b010000;
        end else if (alu_mul_div_valid_ex_i) begin
            stall_o = 6'b000111;
            flush_o = 6'b001000;
        end else if (load_use_valid_id_i) begin
            stall_o = 6'b000011;
            flush_o = 6'b000100;
        end else if (jump_valid_ex_i) begin
            flush_o = 6'b000110;
        end else if (ram_stall_valid_if_i || compress_stall) begin
            // Fetch-side waits: hold PC, feed a bubble into ID.
            stall_o = 6'b000001;
            flush_o = 6'b000010;
        end
    end

endmodule

// File: tb/tb_clint_timer_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clint_timer_pipe_ctrl
//   Directed bench: hand-written timer sequences followed by a table of
//   pipeline request patterns with their expected stall / flush vectors.
// -----------------------------------------------------------------------------
module tb_clint_timer_pipe_ctrl;

    localparam logic [31:0] BASE = 32'h0200_0000;
    localparam logic [31:0] A_CMP_LO   = BASE + 32'h4000;
    localparam logic [31:0] A_CMP_HI   = BASE + 32'h4004;
    localparam logic [31:0] A_MTIME_LO = BASE + 32'hBFF8;
    localparam logic [31:0] A_MTIME_HI = BASE + 32'hBFFC;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;   // [7] trap_flush .. [0] compress, in priority order
    logic [5:0] stall_o;
    logic [5:0] flush_o;

    int total = 0;
    int bad   = 0;

    clint_timer_pipe_ctrl_if bus ();

    clint_timer_pipe_ctrl #(
        .BASE_ADDR (BASE),
        .TICK_DIV  (1)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .bus                    (bus.slave),
        .compress_stall         (req[0]),
        .ram_stall_valid_if_i   (req[1]),
        .ram_stall_valid_mem_i  (req[5]),
        .load_use_valid_id_i    (req[3]),
        .jump_valid_ex_i        (req[2]),
        .alu_mul_div_valid_ex_i (req[4]),
        .trap_flush_valid_wb_i  (req[7]),
        .trap_stall_valid_wb_i  (req[6]),
        .stall_o                (stall_o),
        .flush_o                (flush_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [5:0] stall;
        logic [5:0] flush;
    } pipe_vec_t;

    pipe_vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.mtime_addr_i        = addr;
        bus.mtime_wdata_i       = data;
        bus.mtime_write_valid_i = 1'b1;
        cycle();
        bus.mtime_write_valid_i = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        bus.mtime_addr_i = addr;
        #1;
        check(name, {32'h0, bus.mtime_rdata_o}, {32'h0, exp});
    endtask

    initial begin
        vecs[0]  = '{1'b0, 8'hFF, 6'b000000, 6'b011110};
        vecs[1]  = '{1'b0, 8'h7F, 6'b111111, 6'b000000};
        vecs[2]  = '{1'b0, 8'h3F, 6'b001111, 6'b010000};
        vecs[3]  = '{1'b0, 8'h1F, 6'b000111, 6'b001000};
        vecs[4]  = '{1'b0, 8'h0F, 6'b000011, 6'b000100};
        vecs[5]  = '{1'b0, 8'h07, 6'b000000, 6'b000110};
        vecs[6]  = '{1'b0, 8'h03, 6'b000001, 6'b000010};
        vecs[7]  = '{1'b0, 8'h01, 6'b000001, 6'b000010};
        vecs[8]  = '{1'b0, 8'h00, 6'b000000, 6'b000000};
        vecs[9]  = '{1'b0, 8'h06, 6'b000000, 6'b000110};
        vecs[10] = '{1'b0, 8'h02, 6'b000001, 6'b000010};
        vecs[11] = '{1'b0, 8'h10, 6'b000111, 6'b001000};
        vecs[12] = '{1'b1, 8'hFF, 6'b000000, 6'b000000};
        vecs[13] = '{1'b1, 8'h01, 6'b000000, 6'b000000};

        rst                     = 1'b1;
        req                     = 8'h00;
        bus.mtime_addr_i        = 32'h0;
        bus.mtime_wdata_i       = 32'h0;
        bus.mtime_write_valid_i = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;

        // Reset state
        check("reset_ge", {63'h0, bus.mtime_ge_mtime_o}, 64'h0);
        rd_check("reset_mtime_lo", A_MTIME_LO, 32'h0);
        rd_check("reset_cmp_lo", A_CMP_LO, 32'hFFFF_FFFF);
        rd_check("reset_cmp_hi", A_CMP_HI, 32'hFFFF_FFFF);

        // Idle 10 cycles
        for (int i = 0; i < 10; i++) cycle();
        rd_check("idle_lo", A_MTIME_LO, 32'd10);
        rd_check("idle_hi", A_MTIME_HI, 32'd0);
        check("idle_ge", {63'h0, bus.mtime_ge_mtime_o}, 64'h0);

        // Low-to-high carry
        wr(A_MTIME_LO, 32'hFFFF_FFFF);
        wr(A_MTIME_HI, 32'h0);
        rd_check("pre_carry_lo", A_MTIME_LO, 32'hFFFF_FFFF);
        rd_check("pre_carry_hi", A_MTIME_HI, 32'h0);
        cycle();
        rd_check("carry_lo", A_MTIME_LO, 32'h0);
        rd_check("carry_hi", A_MTIME_HI, 32'h1);

        // Compare sequence: mtimecmp = 20, mtime = 18
        wr(A_CMP_LO, 32'd20);
        wr(A_CMP_HI, 32'd0);
        wr(A_MTIME_HI, 32'd0);
        wr(A_MTIME_LO, 32'd18);
        check("ge_at_18", {63'h0, bus.mtime_ge_mtime_o}, 64'h0);
        cycle();
        check("ge_at_19", {63'h0, bus.mtime_ge_mtime_o}, 64'h0);
        cycle();
        check("ge_at_20", {63'h0, bus.mtime_ge_mtime_o}, 64'h1);
        rd_check("unmapped_read", BASE + 32'h1234, 32'h0);
        rd_check("cmp_lo_readback", A_CMP_LO, 32'd20);

        // Write to an unmapped address changes nothing
        wr(BASE + 32'h1234, 32'hDEAD_BEEF);
        rd_check("unmapped_wr_cmp", A_CMP_LO, 32'd20);
        rd_check("unmapped_wr_read", BASE + 32'h1234, 32'h0);

        // Write in a tick cycle: written value stands
        wr(A_MTIME_LO, 32'h55);
        rd_check("wr_beats_tick", A_MTIME_LO, 32'h55);

        // 64-bit wrap
        wr(A_MTIME_HI, 32'hFFFF_FFFF);
        wr(A_MTIME_LO, 32'hFFFF_FFFF);
        rd_check("max_lo", A_MTIME_LO, 32'hFFFF_FFFF);
        rd_check("max_hi", A_MTIME_HI, 32'hFFFF_FFFF);
        check("max_ge", {63'h0, bus.mtime_ge_mtime_o}, 64'h1);
        cycle();
        rd_check("wrap_lo", A_MTIME_LO, 32'h0);
        rd_check("wrap_hi", A_MTIME_HI, 32'h0);
        check("wrap_ge", {63'h0, bus.mtime_ge_mtime_o}, 64'h0);

        // Pipeline arbiter table
        for (int i = 0; i < 14; i++) begin
            rst = vecs[i].rst;
            req = vecs[i].req;
            #1;
            check($sformatf("pipe_stall[%0d]", i), {58'h0, stall_o}, {58'h0, vecs[i].stall});
            check($sformatf("pipe_flush[%0d]", i), {58'h0, flush_o}, {58'h0, vecs[i].flush});
            check($sformatf("pipe_overlap[%0d]", i), {58'h0, stall_o & flush_o}, 64'h0);
        end

        rst = 1'b0;
        req = 8'h00;
        cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
